// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display scheduler.
package disp_sched_pkg;

  localparam int DISP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_RESULT = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  // Encodings for the src output telling the board which source is shown.
  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_ENTRY  = 2'd1;
  localparam logic [1:0] SRC_RESULT = 2'd2;
  localparam logic [1:0] SRC_ERR    = 2'd3;

  // State to fall back to once an error notice has been shown long enough.
  function automatic state_e return_target(input logic have_res,
                                           input logic entry_valid);
    if (have_res) begin
      return ST_RESULT;
    end else if (entry_valid) begin
      return ST_ENTRY;
    end
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/disp_hold_timer.sv
// Loadable down-counter. A load sets it to PERIOD-1; while running it counts
// down and pulses o_expired for one cycle on reaching zero, then reloads,
// so with run held high it expires every PERIOD cycles.
module disp_hold_timer #(
  parameter int unsigned PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(PERIOD + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;

  // A load in the same cycle takes precedence and suppresses the pulse.
  assign o_expired = i_run && !i_load && (r_cnt == '0);

  // Count register: load, count down, and auto-reload on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all state, so every register samples
    // pre-edge values regardless of statement or block ordering.
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (i_run) begin
      if (r_cnt == '0) begin
        r_cnt <= RELOAD;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/disp_scheduler.sv
// Arbitrates entry, result and error sources onto the single decimal display.
// Error > result strobe > entry edge > timer expiry. All outputs are
// registered from the next state, so they change one cycle after an event.
module disp_scheduler
  import disp_sched_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DISP_W-1:0] entry_value,
  input  logic              entry_valid,
  input  logic [DISP_W-1:0] result_value,
  input  logic              result_strobe,
  input  logic              result_non_signed,
  input  logic              overflow,
  input  logic              err_strobe,
  input  logic              mode_toggle,
  output logic [DISP_W-1:0] value,
  output logic              non_signed,
  output logic              enable,
  output logic              err_show,
  output logic [1:0]        src
);

  state_e            r_state, w_state_nxt;
  state_e            r_target, w_target_nxt;
  logic [DISP_W-1:0] r_res, w_res_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              r_view_ns, w_view_ns_nxt;
  logic              r_have_res, w_have_res_nxt;
  logic              r_phase, w_phase_nxt;
  logic              r_entry_d;
  logic              w_entry_rise;
  logic              w_hold_expired;
  logic              w_blink_expired;
  logic              w_blink_restart;
  logic [DISP_W-1:0] w_value_nxt;
  logic              w_ns_nxt, w_en_nxt, w_err_nxt;
  logic [1:0]        w_src_nxt;

  assign w_entry_rise = entry_valid && !r_entry_d;

  // Blink phase restarts on every entry into RESULT and on every new result.
  assign w_blink_restart = (w_state_nxt == ST_RESULT) &&
                           ((r_state != ST_RESULT) || result_strobe);

  disp_hold_timer #(.PERIOD(HOLD_CYCLES)) u_hold_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (err_strobe),
    .i_run     (r_state == ST_ERROR),
    .o_expired (w_hold_expired)
  );

  disp_hold_timer #(.PERIOD(BLINK_CYCLES)) u_blink_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_blink_restart),
    .i_run     ((r_state == ST_RESULT) && r_ovf),
    .o_expired (w_blink_expired)
  );

  // Result latch and view toggle; a toggle coinciding with a new result is dropped.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_res_nxt      = r_res;
    w_ovf_nxt      = r_ovf;
    w_view_ns_nxt  = r_view_ns;
    w_have_res_nxt = r_have_res;
    if (result_strobe) begin
      w_res_nxt      = result_value;
      w_ovf_nxt      = overflow;
      w_view_ns_nxt  = result_non_signed;
      w_have_res_nxt = 1'b1;
    end else if ((r_state == ST_RESULT) && mode_toggle) begin
      w_view_ns_nxt = !r_view_ns;
    end
  end

  // Next state and error return target, in priority order.
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    if (err_strobe) begin
      w_state_nxt = ST_ERROR;
      // A retrigger keeps the target unless a result arrives alongside it.
      if ((r_state != ST_ERROR) || result_strobe) begin
        w_target_nxt = return_target(r_have_res || result_strobe, entry_valid);
      end
    end else if (result_strobe) begin
      if (r_state == ST_ERROR) begin
        w_target_nxt = ST_RESULT;
      end else begin
        w_state_nxt = ST_RESULT;
      end
    end else begin
      unique case (r_state)
        ST_IDLE:   if (entry_valid) w_state_nxt = ST_ENTRY;
        ST_ENTRY:  if (!entry_valid) w_state_nxt = r_have_res ? ST_RESULT : ST_IDLE;
        ST_RESULT: if (w_entry_rise) w_state_nxt = ST_ENTRY;
        ST_ERROR:  if (w_hold_expired) w_state_nxt = r_target;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Blink phase: forced on at restart, toggled on each half-period expiry.
  always_comb begin
    w_phase_nxt = r_phase;
    if (w_blink_restart) begin
      w_phase_nxt = 1'b1;
    end else if (w_blink_expired) begin
      w_phase_nxt = !r_phase;
    end
  end

  // Output values for the state being entered; ERROR holds value and view.
  always_comb begin
    w_value_nxt = value;
    w_ns_nxt    = non_signed;
    w_en_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_src_nxt   = SRC_NONE;
    unique case (w_state_nxt)
      ST_IDLE: begin
        w_value_nxt = '0;
        w_ns_nxt    = 1'b0;
      end
      ST_ENTRY: begin
        w_value_nxt = entry_value;
        w_ns_nxt    = 1'b0;
        w_en_nxt    = 1'b1;
        w_src_nxt   = SRC_ENTRY;
      end
      ST_RESULT: begin
        w_value_nxt = w_res_nxt;
        w_ns_nxt    = w_view_ns_nxt;
        w_en_nxt    = w_ovf_nxt ? w_phase_nxt : 1'b1;
        w_src_nxt   = SRC_RESULT;
      end
      ST_ERROR: begin
        w_en_nxt  = 1'b1;
        w_err_nxt = 1'b1;
        w_src_nxt = SRC_ERR;
      end
      default: begin
        w_src_nxt = SRC_NONE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_target <= ST_IDLE;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
    end
  end

  // Latches, blink phase and entry edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res      <= '0;
      r_ovf      <= 1'b0;
      r_view_ns  <= 1'b0;
      r_have_res <= 1'b0;
      r_phase    <= 1'b0;
      r_entry_d  <= 1'b0;
    end else begin
      r_res      <= w_res_nxt;
      r_ovf      <= w_ovf_nxt;
      r_view_ns  <= w_view_ns_nxt;
      r_have_res <= w_have_res_nxt;
      r_phase    <= w_phase_nxt;
      r_entry_d  <= entry_valid;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value      <= '0;
      non_signed <= 1'b0;
      enable     <= 1'b0;
      err_show   <= 1'b0;
      src        <= SRC_NONE;
    end else begin
      value      <= w_value_nxt;
      non_signed <= w_ns_nxt;
      enable     <= w_en_nxt;
      err_show   <= w_err_nxt;
      src        <= w_src_nxt;
    end
  end

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed bench for disp_scheduler with HOLD_CYCLES=8 and BLINK_CYCLES=3.
// Outputs are compared as one bundle {value, non_signed, enable, err_show, src}.
module tb_disp_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] entry_value;
  logic       entry_valid;
  logic [7:0] result_value;
  logic       result_strobe;
  logic       result_non_signed;
  logic       overflow;
  logic       err_strobe;
  logic       mode_toggle;
  logic [7:0] value;
  logic       non_signed;
  logic       enable;
  logic       err_show;
  logic [1:0] src;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       ev;
    logic [7:0] ent;
    logic       rs;
    logic [7:0] rv;
    logic       rns;
    logic       ovf;
    logic       es;
    logic       mt;
    logic [12:0] exp_out;
  } vec_t;

  disp_scheduler #(.HOLD_CYCLES(8), .BLINK_CYCLES(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .entry_value       (entry_value),
    .entry_valid       (entry_valid),
    .result_value      (result_value),
    .result_strobe     (result_strobe),
    .result_non_signed (result_non_signed),
    .overflow          (overflow),
    .err_strobe        (err_strobe),
    .mode_toggle       (mode_toggle),
    .value             (value),
    .non_signed        (non_signed),
    .enable            (enable),
    .err_show          (err_show),
    .src               (src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] pack_out(input logic [7:0] v, input logic ns,
                                           input logic en, input logic er,
                                           input logic [1:0] s);
    return {v, ns, en, er, s};
  endfunction

  task automatic check(input string name, input logic [12:0] exp_v);
    logic [12:0] act;
    act = {value, non_signed, enable, err_show, src};
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got value=%h ns=%b en=%b err=%b src=%0d, want value=%h ns=%b en=%b err=%b src=%0d",
               name, act[12:5], act[4], act[3], act[2], act[1:0],
               exp_v[12:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    entry_valid       = 1'b0;
    entry_value       = 8'h00;
    result_strobe     = 1'b0;
    result_value      = 8'h00;
    result_non_signed = 1'b0;
    overflow          = 1'b0;
    err_strobe        = 1'b0;
    mode_toggle       = 1'b0;
  endtask

  function automatic vec_t mk(input logic ev, input logic [7:0] ent,
                              input logic rs, input logic [7:0] rv,
                              input logic rns, input logic mt,
                              input logic [12:0] eo);
    vec_t v;
    v.ev = ev; v.ent = ent; v.rs = rs; v.rv = rv; v.rns = rns;
    v.ovf = 1'b0; v.es = 1'b0; v.mt = mt; v.exp_out = eo;
    return v;
  endfunction

  vec_t vecs[13];
  int   blink_a[5];
  int   blink_b[7];

  initial begin
    // Idle -> entry -> idle, then result, view toggles, entry interrupting result.
    vecs[0]  = mk(0, 8'h00, 0, 8'h00, 0, 0, pack_out(8'h00, 0, 0, 0, 0));
    vecs[1]  = mk(1, 8'hF4, 0, 8'h00, 0, 0, pack_out(8'hF4, 0, 1, 0, 1));
    vecs[2]  = mk(1, 8'h05, 0, 8'h00, 0, 0, pack_out(8'h05, 0, 1, 0, 1));
    vecs[3]  = mk(0, 8'h05, 0, 8'h00, 0, 0, pack_out(8'h00, 0, 0, 0, 0));
    vecs[4]  = mk(1, 8'h07, 0, 8'h00, 0, 0, pack_out(8'h07, 0, 1, 0, 1));
    vecs[5]  = mk(1, 8'h07, 1, 8'hFF, 1, 0, pack_out(8'hFF, 1, 1, 0, 2));
    vecs[6]  = mk(0, 8'h00, 0, 8'h00, 0, 1, pack_out(8'hFF, 0, 1, 0, 2));
    vecs[7]  = mk(0, 8'h00, 0, 8'h00, 0, 1, pack_out(8'hFF, 1, 1, 0, 2));
    vecs[8]  = mk(0, 8'h00, 1, 8'hFF, 1, 1, pack_out(8'hFF, 1, 1, 0, 2));
    vecs[9]  = mk(0, 8'h00, 0, 8'h00, 0, 0, pack_out(8'hFF, 1, 1, 0, 2));
    vecs[10] = mk(1, 8'h33, 0, 8'h00, 0, 0, pack_out(8'h33, 0, 1, 0, 1));
    vecs[11] = mk(1, 8'h34, 0, 8'h00, 0, 0, pack_out(8'h34, 0, 1, 0, 1));
    vecs[12] = mk(0, 8'h00, 0, 8'h00, 0, 0, pack_out(8'hFF, 1, 1, 0, 2));
    blink_a = '{1, 1, 1, 0, 0};
    blink_b = '{1, 1, 1, 0, 0, 0, 1};

    // Reset state
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", pack_out(8'h00, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Error with nothing to return to: 8 cycles of Err, then back to IDLE.
    err_strobe = 1'b1;
    step();
    err_strobe = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("idle_err_c%0d", c), pack_out(8'h00, 0, 1, 1, 3));
      if (c < 8) step();
    end
    step();
    check("idle_err_return", pack_out(8'h00, 0, 0, 0, 0));

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 13; i++) begin
      entry_valid       = vecs[i].ev;
      entry_value       = vecs[i].ent;
      result_strobe     = vecs[i].rs;
      result_value      = vecs[i].rv;
      result_non_signed = vecs[i].rns;
      overflow          = vecs[i].ovf;
      err_strobe        = vecs[i].es;
      mode_toggle       = vecs[i].mt;
      step();
      check($sformatf("vec%0d", i), vecs[i].exp_out);
    end
    clear_inputs();

    // Error from RESULT: exactly 8 cycles of Err, value held, then RESULT 255.
    err_strobe = 1'b1;
    step();
    err_strobe = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("err_c%0d", c), pack_out(8'hFF, 1, 1, 1, 3));
      if (c < 8) step();
    end
    step();
    check("err_return", pack_out(8'hFF, 1, 1, 0, 2));

    // Retrigger in the fifth ERROR cycle stretches ERROR to 13 cycles.
    err_strobe = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      err_strobe = (c == 5);
      check($sformatf("retrig_c%0d", c), pack_out(8'hFF, 1, 1, 1, 3));
    end
    step();
    check("retrig_return", pack_out(8'hFF, 1, 1, 0, 2));

    // Simultaneous error and result strobes: ERROR first, then RESULT 43.
    err_strobe    = 1'b1;
    result_strobe = 1'b1;
    result_value  = 8'd43;
    step();
    clear_inputs();
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("simul_c%0d", c), pack_out(8'hFF, 1, 1, 1, 3));
      if (c < 8) step();
    end
    step();
    check("simul_return", pack_out(8'd43, 0, 1, 0, 2));

    // Overflow blink: 1,1,1,0,0 then an entry interrupts it.
    result_strobe = 1'b1;
    result_value  = 8'h90;
    overflow      = 1'b1;
    step();
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("blink_a%0d", c), pack_out(8'h90, 0, blink_a[c][0], 0, 2));
      if (c < 4) step();
    end
    entry_valid = 1'b1;
    entry_value = 8'h01;
    step();
    check("blink_entry", pack_out(8'h01, 0, 1, 0, 1));
    entry_valid = 1'b0;
    // Returning to RESULT restarts the blink at the on phase.
    for (int c = 0; c < 7; c++) begin
      step();
      check($sformatf("blink_b%0d", c), pack_out(8'h90, 0, blink_b[c][0], 0, 2));
    end

    // A result without overflow keeps the display steadily on.
    result_strobe     = 1'b1;
    result_value      = 8'h12;
    result_non_signed = 1'b1;
    step();
    clear_inputs();
    for (int c = 0; c < 7; c++) begin
      check($sformatf("steady%0d", c), pack_out(8'h12, 1, 1, 0, 2));
      step();
    end

    // Reset in the middle of an error hold clears everything immediately.
    err_strobe = 1'b1;
    step();
    err_strobe = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_hold", pack_out(8'h00, 0, 0, 0, 0));
    #2;
    rst_n = 1'b1;
    step();
    check("after_reset_idle", pack_out(8'h00, 0, 0, 0, 0));
    entry_valid = 1'b1;
    entry_value = 8'h05;
    step();
    check("after_reset_entry", pack_out(8'h05, 0, 1, 0, 1));
    entry_valid = 1'b0;
    step();
    check("after_reset_no_result", pack_out(8'h00, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

Sequencing controller that owns the single `disp_decimal` instance on the calculator board and decides, every cycle, what it shows. Three sources compete for it: the operand being keyed in, the latest RPN result, and transient error notices. The block arbitrates them by fixed priority, holds error notices for a programmable time, blinks overflowed results, and tracks the signed/unsigned view. Its registered outputs drive `value`, `non_signed` and `enable` of `disp_decimal` directly, plus an error-pattern select for the segment mux.

## Interface
- `HOLD_CYCLES`, 50_000_000 — error notice duration in clocks (1 s at 50 MHz); legal range is ≥2.
- `BLINK_CYCLES`, 12_500_000 — half-period of the overflow blink in clocks; legal range is ≥1.
- `clk`  in  1  — system clock; all state changes on its rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `entry_value`  in  8  — operand currently being keyed, two's complement.
- `entry_valid`  in  1  — level; high while an operand entry is in progress.
- `result_value`  in  8  — new result from the RPN datapath.
- `result_strobe`  in  1  — one-cycle pulse; `result_value`, `result_non_signed` and `overflow` are valid in this cycle.
- `result_non_signed`  in  1  — default view for this result.
- `overflow`  in  1  — the result overflowed 8 bits.
- `err_strobe`  in  1  — one-cycle pulse; an error occurred (stack underflow or divide by zero).
- `mode_toggle`  in  1  — one-cycle pulse; invert the signed/unsigned view of the displayed result.
- `value`  out  8  — to `disp_decimal.value`.
- `non_signed`  out  1  — to `disp_decimal.non_signed`.
- `enable`  out  1  — to `disp_decimal.enable`.
- `err_show`  out  1  — selects the "Err" segment pattern instead of the decoder output.
- `src`  out  2  — which source is shown: 0 = none, 1 = entry, 2 = result, 3 = error.

## Operation
- **FSM states.** IDLE, ENTRY, RESULT, ERROR. Each output is a registered function of the state and the latches.
- **IDLE.** Outputs `enable=0`, `value=0`, `src=0`.
- **ENTRY.** Outputs `value=entry_value` (tracked every cycle), `non_signed=0`, `enable=1`, `src=1`.
- **RESULT.** Outputs `value=res_q`, `non_signed=view_ns`, `src=2`. `enable=1`, or the blink phase when `ovf_q=1`.
- **ERROR.** Outputs `err_show=1`, `enable=1`, `src=3`. `value` holds its previous value.
- **Priority per cycle.** `err_strobe` > `result_strobe` > `entry_valid` rising edge > timer expiry.
- **Result latch.** `result_strobe` loads `res_q`, `ovf_q` and `view_ns=result_non_signed`, and sets `have_res`. It does this in every state, including ERROR.
- **Transitions.**
  - IDLE → ENTRY when `entry_valid=1`.
  - ENTRY → IDLE when `entry_valid=0` and `have_res=0`.
  - ENTRY → RESULT when `entry_valid=0` and `have_res=1`.
  - any state → RESULT on `result_strobe`.
  - RESULT → ENTRY on a 0→1 edge of `entry_valid`.
  - any state → ERROR on `err_strobe`. The return target is captured as RESULT if `have_res`, else ENTRY if `entry_valid`, else IDLE.
  - ERROR → the captured target after `HOLD_CYCLES` cycles. A `result_strobe` during ERROR changes the target to RESULT.
- **mode_toggle.** Inverts `view_ns` only in RESULT. It is ignored when it arrives in the same cycle as `result_strobe`, and ignored in all other states.
- **Blink.** Active in RESULT with `ovf_q=1`. The counter restarts on every entry into RESULT and on every `result_strobe`. `enable` starts at 1 and toggles every `BLINK_CYCLES` cycles.

## Timing
- **Reset values** (asserted asynchronously):
  - outputs: `value=0`, `non_signed=0`, `enable=0`, `err_show=0`, `src=0`;
  - internal: state IDLE, `have_res=0`, `ovf_q=0`, `view_ns=0`, both counters 0.
- **Latency.** One cycle from a registered event (strobe, edge, expiry) to the new outputs.
- **Hold timing.** ERROR is entered on cycle N+1 after `err_strobe` at N. Outputs show the target state on cycle N+1+HOLD_CYCLES.
- **Error retrigger.** A new `err_strobe` while in ERROR reloads the hold counter to a full `HOLD_CYCLES`. The return target is kept.
- **Simultaneous strobes.** `err_strobe` together with `result_strobe`: ERROR wins, the result is latched, and the target becomes RESULT.
- **Entry tracking.** In ENTRY, `value` follows `entry_value` with one cycle of delay.
- **Reset mid-hold or mid-blink.** Counters and latches clear immediately; there is no partial resume.

## Structure
- Package `disp_sched_pkg` holds:
  - the state enum;
  - the `src` encodings SRC_NONE, SRC_ENTRY, SRC_RESULT, SRC_ERR;
  - the data width constant `DISP_W=8`.
- Sub-module `disp_hold_timer` is a loadable down-counter with load, run and a one-cycle `expired` pulse. It is instantiated twice: once for the error hold, once for the blink half-period.
- `disp_decimal` is instantiated by the parent, not inside this block.

## Test plan
All directed tests use `HOLD_CYCLES=8` and `BLINK_CYCLES=3`.
1. **Reset.** Assert reset, release, then raise `entry_valid` with `entry_value=-12` → `src=1`, `value=8'hF4`, `non_signed=0`, `enable=1` one cycle later.
2. **Result and view toggle.** `result_strobe` with `result_value=255`, `result_non_signed=1` → `src=2`, `non_signed=1`. Then `mode_toggle` → `non_signed=0`. A toggle in the same cycle as a strobe is ignored.
3. **Error and return.** `err_strobe` while in RESULT → `err_show=1` for exactly 8 cycles, then `src=2` with `value=255`. A retrigger at cycle 5 extends ERROR to 13 cycles total.
4. **Simultaneous strobes.** `err_strobe` and `result_strobe` (value 43) in the same cycle → ERROR, then after 8 cycles RESULT with `value=43`.
5. **Overflow blink.** `result_strobe` with `overflow=1` → `enable` reads 1,1,1,0,0,0,1… After a new strobe with `overflow=0`, `enable` stays at 1.
6. **Entry interrupts result.** In RESULT, an `entry_valid` 0→1 edge → ENTRY. When `entry_valid` falls → back to RESULT, because `have_res=1`.
